// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control stage and the sequential ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             v;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_op, a, b,
        input  result, v, zero, busy, done
    );

    modport slave (
        input  start, alu_op, a, b,
        output result, v, zero, busy, done
    );
endinterface

// File: rtl/alu_mod_unit.sv
// Restoring remainder engine: one dividend bit per step, MSB first, WIDTH steps.
module alu_mod_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_dvd_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_last
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // The partial remainder never exceeds the dividend prefix seen so far, so
    // its MSB stays clear until the final step, whose full value leaves via o_rem.
    logic [WIDTH-2:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_shift;

    assign w_shift = {r_rem, i_dvd_bit};
    assign o_rem   = (w_shift >= i_b) ? (w_shift - i_b) : w_shift;
    assign o_last  = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_cnt <= CNT_W'(WIDTH);
        end else if (i_step) begin
            r_rem <= o_rem[WIDTH-2:0];
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit MIPS ALU: logic/slt/add/sub in one cycle,
// unsigned modulo through the iterative remainder engine.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_v;
    logic             r_zero;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_b;

    logic             w_accept;
    logic             w_mod_iter;
    logic             w_wr_alu;
    logic             w_step;
    logic             w_last;
    logic             w_wr_mod;
    logic             w_inv;
    logic             w_ovf;
    logic             w_set;
    logic             w_v;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH:0]   w_sum;

    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_mod_iter = w_accept && (bus.alu_op == OP_MOD) && (bus.b != '0);
    assign w_wr_alu   = w_accept && !w_mod_iter;
    assign w_step     = (r_state == ST_CALC);
    assign w_wr_mod   = w_step && w_last;

    // One shared adder: sub and slt invert b and inject a carry-in of 1.
    assign w_inv = (bus.alu_op == OP_SUB) || (bus.alu_op == OP_SLT);
    assign w_bx  = w_inv ? ~bus.b : bus.b;
    assign w_sum = {1'b0, bus.a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_inv};
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign w_ovf = (w_sum[WIDTH-1] ^ bus.a[WIDTH-1] ^ w_bx[WIDTH-1]) ^ w_sum[WIDTH];
    assign w_set = w_sum[WIDTH-1] ^ w_ovf;

    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        case (bus.alu_op)
            OP_AND:  w_res = bus.a & bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_XOR:  w_res = bus.a ^ bus.b;
            OP_NOR:  w_res = ~(bus.a | bus.b);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_set};
            OP_ADD,
            OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_v   = w_ovf;
            end
            default: w_res = bus.a;  // mod reaches here only with b == 0
        endcase
    end

    alu_mod_unit #(
        .WIDTH(WIDTH)
    ) u_mod (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_mod_iter),
        .i_step   (w_step),
        .i_b      (r_b),
        .i_dvd_bit(r_dvd[WIDTH-1]),
        .o_rem    (w_rem),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = w_mod_iter ? ST_CALC : ST_DONE;
            ST_CALC: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            ST_CALC: bus.busy = 1'b1;
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Result flags move only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_v      <= 1'b0;
            r_zero   <= 1'b1;
        end else if (w_wr_alu) begin
            r_result <= w_res;
            r_v      <= w_v;
            r_zero   <= (w_res == '0);
        end else if (w_wr_mod) begin
            r_result <= w_rem;
            r_v      <= 1'b0;
            r_zero   <= (w_rem == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mod_iter) begin
            r_dvd <= bus.a;
            r_b   <= bus.b;
        end else if (w_step) begin
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
        end
    end

    assign bus.result = r_result;
    assign bus.v      = r_v;
    assign bus.zero   = r_zero;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the MIPS datapath, replacing the chain of 1-bit slices with a single WIDTH-bit unit. Executes the same 3-bit ALUop set:
- Logic, set-less-than, add and subtract complete in one cycle.
- Unsigned modulo runs as an iterative restoring remainder over WIDTH cycles.

Sits between the register-file read stage and writeback. Control stalls on `busy` and consumes the result on `done`.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; legal values ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low; one clock domain
- start  in  1  request; sampled only in IDLE
- alu_op  in  3  000 and, 001 or, 010 xor, 011 nor, 100 slt, 101 add, 110 sub, 111 mod
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- result  out  WIDTH  registered result; holds until next accepted start
- v  out  1  signed overflow; valid for add/sub, 0 for all other ops
- zero  out  1  result == 0
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when result/v/zero become valid

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - On start, operands and op are latched.
  - Non-mod ops: result is computed and registered the same edge; go to DONE.
  - mod with b ≠ 0: clear remainder, load counter with WIDTH, go to CALC.
  - mod with b == 0: result = a; go to DONE.
- CALC, one iteration per cycle:
  - Form r' = {rem[WIDTH-2:0], next dividend bit}, taking dividend bits MSB first.
  - If r' ≥ b then rem = r' − b, else rem = r'.
  - Decrement the counter. When it reaches 0, write rem to result and go to DONE.
- DONE: done=1 for exactly one cycle; return to IDLE.
- busy is 1 in CALC and DONE, and 0 in IDLE.
- start is ignored outside IDLE. Operand and alu_op changes after acceptance have no effect.
- add/sub use a single WIDTH+1 adder, with b inverted and carry-in 1 for sub and slt.
- v = carry into MSB XOR carry out of MSB.
- slt: set = sign(a−b) XOR v. result = {WIDTH-1 zeros, set}.
- nor = ~(a|b). Logic ops are bitwise over WIDTH.
- All arithmetic wraps modulo 2^WIDTH.
- Reset (any time, including mid-CALC):
  - state IDLE.
  - result, v, busy and done all 0.
  - zero = 1, consistent with result = 0.
  - Remainder and counter cleared.
  - No pulse on done after reset release.

## Timing
- Start accepted at edge T:
  - Non-mod op, or mod with b == 0: result valid and done=1 in cycle T+1; IDLE at T+2.
  - mod with b ≠ 0: CALC spans WIDTH cycles; result valid and done=1 in cycle T+WIDTH+1; IDLE at T+WIDTH+2.
- start asserted in the same cycle as done is ignored. Back-to-back throughput is one op every 2 cycles for non-mod ops.
- result, v and zero change only on the edge that raises done, or on reset.

## Structure
Shared package alu_pkg holds:
- the ALUop encodings as localparams (OP_AND … OP_MOD);
- the state encoding for IDLE/CALC/DONE.

Sub-module alu_mod_unit, parametrised by WIDTH:
- holds the remainder register, counter and compare/subtract;
- ports: load, b, dividend-bit input, rem output, last flag.

alu_seq contains the FSM, the adder/logic datapath and the output registers.

## Test plan
All scenarios use WIDTH=32.
- add: a=0x7FFFFFFF, b=1 → result 0x80000000, v=1, done at T+1, busy high 1 cycle.
- sub: a=5, b=5 → result 0, zero=1, v=0. Then slt: a=0xFFFFFFFF (−1), b=1 → result 1.
- mod: a=100, b=7 → busy 33 cycles; done at T+33, result 2. a=0xFFFFFFFF, b=0x10 → 0xF.
- Edge cases:
  - mod with b=0, a=0x1234 → result 0x1234, done at T+1.
  - mod with a<b (3 mod 9) → result 3.
- Control:
  - start held high and alu_op/a/b changed during CALC → ignored; original mod result delivered.
  - rst_n pulsed low mid-CALC → result 0, zero=1, busy=0, and done never pulses.
- Random sweep, including WIDTH=8: compare every op against a reference model. Check latency, one-cycle done, and v=0 for non-add/sub ops.
